// File: rtl/integer_pe_requant.sv
// Requantization drain stage for the integer systolic PE: scale multiply,
// round-half-up arithmetic shift and saturation in a 3-stage valid/ready pipeline.
module integer_pe_requant #(
  parameter int ACC        = 32,
  parameter int OUT        = 8,
  parameter int SCALE      = 16,
  parameter int SHIFT_BITS = 6,
  parameter int CNT        = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [ACC-1:0]        accIn,
  input  logic signed [SCALE-1:0]      scaleIn,
  input  logic        [SHIFT_BITS-1:0] shiftIn,
  input  logic                         inValid,
  output logic                         inReady,
  output logic signed [OUT-1:0]        outData,
  output logic                         outSat,
  output logic                         outValid,
  input  logic                         outReady,
  input  logic                         clearCounts,
  output logic        [CNT-1:0]        satCount,
  output logic        [CNT-1:0]        beatCount
);

  localparam int PROD      = ACC + SCALE;
  localparam int RW        = PROD + 1;
  localparam int MAX_SHIFT = PROD - 1;

  localparam logic [SHIFT_BITS-1:0] MAX_SHIFT_W = SHIFT_BITS'(MAX_SHIFT);
  localparam logic signed [RW-1:0]  ONE_W       = RW'(1);
  localparam logic signed [RW-1:0]  SAT_MAX     = RW'((2 ** (OUT - 1)) - 1);
  localparam logic signed [RW-1:0]  SAT_MIN     = ~SAT_MAX;

  // Stage valids and per-stage load enables
  logic stage1_valid_reg, stage2_valid_reg, stage3_valid_reg;
  logic load1, load2, load3;

  // Stage 1 payload
  logic signed [ACC-1:0]        acc1_reg;
  logic signed [SCALE-1:0]      scale1_reg;
  logic        [SHIFT_BITS-1:0] shift1_reg;
  logic        [SHIFT_BITS-1:0] shift_clamped;

  // Stage 2 payload
  logic signed [PROD-1:0]       prod2_reg;
  logic signed [PROD-1:0]       prod_next;
  logic        [SHIFT_BITS-1:0] shift2_reg;

  // Stage 3 combinational rounding/saturation
  logic signed [RW-1:0]         prod_ext;
  logic signed [RW-1:0]         round_bias;
  logic signed [RW-1:0]         rounded;
  logic signed [OUT-1:0]        sat_data_next;
  logic                         sat_flag_next;

  logic delivered;

  // A stage loads when empty or when the stage after it loads this cycle
  assign load3    = !stage3_valid_reg | outReady;
  assign load2    = !stage2_valid_reg | load3;
  assign load1    = !stage1_valid_reg | load2;
  assign inReady  = load1;
  assign outValid = stage3_valid_reg;

  assign delivered = stage3_valid_reg & outReady;

  always_comb begin
    shift_clamped = shiftIn;
    if (32'(shiftIn) > MAX_SHIFT) begin
      shift_clamped = MAX_SHIFT_W;
    end
  end

  assign prod_next = PROD'(acc1_reg) * PROD'(scale1_reg);

  // Extra headroom bit keeps the rounding add from overflowing
  always_comb begin
    prod_ext   = RW'(prod2_reg);
    round_bias = '0;
    if (shift2_reg != '0) begin
      round_bias = ONE_W <<< (shift2_reg - SHIFT_BITS'(1));
    end
    rounded = (prod_ext + round_bias) >>> shift2_reg;
  end

  always_comb begin
    sat_data_next = rounded[OUT-1:0];
    sat_flag_next = 1'b0;
    if (rounded > SAT_MAX) begin
      sat_data_next = SAT_MAX[OUT-1:0];
      sat_flag_next = 1'b1;
    end else if (rounded < SAT_MIN) begin
      sat_data_next = SAT_MIN[OUT-1:0];
      sat_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage1_valid_reg <= 1'b0;
      stage2_valid_reg <= 1'b0;
      stage3_valid_reg <= 1'b0;
    end else begin
      if (load1) stage1_valid_reg <= inValid;
      if (load2) stage2_valid_reg <= stage1_valid_reg;
      if (load3) stage3_valid_reg <= stage2_valid_reg;
    end
  end

  // Payloads only move with a valid beat; bubbles leave them untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc1_reg   <= '0;
      scale1_reg <= '0;
      shift1_reg <= '0;
    end else if (load1 && inValid) begin
      acc1_reg   <= accIn;
      scale1_reg <= scaleIn;
      shift1_reg <= shift_clamped;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod2_reg  <= '0;
      shift2_reg <= '0;
    end else if (load2 && stage1_valid_reg) begin
      prod2_reg  <= prod_next;
      shift2_reg <= shift1_reg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outData <= '0;
      outSat  <= 1'b0;
    end else if (load3 && stage2_valid_reg) begin
      outData <= sat_data_next;
      outSat  <= sat_flag_next;
    end
  end

  // Clear has priority over a coincident delivery
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      satCount  <= '0;
      beatCount <= '0;
    end else if (clearCounts) begin
      satCount  <= '0;
      beatCount <= '0;
    end else if (delivered) begin
      beatCount <= beatCount + CNT'(1);
      if (outSat && (satCount != '1)) begin
        satCount <= satCount + CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_integer_pe_requant.sv
// Directed self-checking bench for integer_pe_requant: rounding, saturation,
// backpressure ordering, asynchronous reset and counter edge cases.
module tb_integer_pe_requant;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [31:0] accIn;
  logic signed [15:0] scaleIn;
  logic        [5:0]  shiftIn;
  logic               inValid;
  logic               inReady;
  logic signed [7:0]  outData;
  logic               outSat;
  logic               outValid;
  logic               outReady;
  logic               clearCounts;
  logic        [15:0] satCount;
  logic        [15:0] beatCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  integer_pe_requant dut (
    .clock      (clock),
    .reset      (reset),
    .accIn      (accIn),
    .scaleIn    (scaleIn),
    .shiftIn    (shiftIn),
    .inValid    (inValid),
    .inReady    (inReady),
    .outData    (outData),
    .outSat     (outSat),
    .outValid   (outValid),
    .outReady   (outReady),
    .clearCounts(clearCounts),
    .satCount   (satCount),
    .beatCount  (beatCount)
  );

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One isolated beat: checks acceptance, 3-cycle latency and the result
  task automatic send_one(input string tag, input logic signed [31:0] acc,
                          input logic signed [15:0] sc, input logic [5:0] sh,
                          input int exp_d, input logic exp_s);
    @(posedge clock); #1;
    accIn = acc; scaleIn = sc; shiftIn = sh; inValid = 1'b1; outReady = 1'b1;
    @(negedge clock);
    check_val({tag, "_inready"}, inReady, 1);
    @(posedge clock); #1;
    inValid = 1'b0;
    accIn   = $urandom;
    scaleIn = 16'($urandom);
    shiftIn = 6'($urandom);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      if (i < 3) begin
        check_val({tag, "_early_valid"}, outValid, 0);
      end else begin
        check_val({tag, "_valid"}, outValid, 1);
        check_val({tag, "_data"}, outData, exp_d);
        check_val({tag, "_sat"}, outSat, exp_s);
      end
    end
    $display("beat %s: acc=%0d scale=%0d shift=%0d -> out=%0d sat=%0b",
             tag, acc, sc, sh, outData, outSat);
  endtask

  // n consecutive accepts; caller guarantees inReady stays high
  task automatic stream(input int n, input logic signed [31:0] acc,
                        input logic signed [15:0] sc, input logic [5:0] sh);
    @(posedge clock); #1;
    accIn = acc; scaleIn = sc; shiftIn = sh; inValid = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    inValid = 1'b0;
    $display("stream: %0d beats acc=%0d scale=%0d shift=%0d", n, acc, sc, sh);
  endtask

  task automatic drain();
    outReady = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic clear_pulse();
    @(posedge clock); #1;
    clearCounts = 1'b1;
    @(posedge clock); #1;
    clearCounts = 1'b0;
  endtask

  int idx;
  int exp_idx;
  int first_drop;
  int held;

  initial begin
    reset = 1'b1; inValid = 1'b0; outReady = 1'b1; clearCounts = 1'b0;
    accIn = '0; scaleIn = '0; shiftIn = '0;
    #12;
    check_val("rst_outvalid", outValid, 0);
    check_val("rst_outdata", outData, 0);
    check_val("rst_outsat", outSat, 0);
    check_val("rst_satcount", satCount, 0);
    check_val("rst_beatcount", beatCount, 0);
    check_val("rst_inready", inReady, 1);
    reset = 1'b0;

    // Rounding: scale 1, shift 3
    send_one("exact", 1000, 1, 3, 125, 0);
    send_one("tie", 1004, 1, 3, 126, 0);
    send_one("neg", -1004, 1, 3, -125, 0);
    @(posedge clock); #1;
    check_val("beats_after_round", beatCount, 3);
    clearCounts = 1'b1;
    @(posedge clock); #1;
    clearCounts = 1'b0;
    @(negedge clock);
    check_val("clear_beat", beatCount, 0);

    // Saturation
    send_one("sat_pos", 100000, 1, 0, 127, 1);
    send_one("sat_neg", -100000, 1, 0, -128, 1);
    @(posedge clock); @(negedge clock);
    check_val("sat_count2", satCount, 2);
    check_val("beat_count2", beatCount, 2);

    // Scale and shift path, including shift clamp
    send_one("scale_a", -300, 3, 2, -128, 1);
    send_one("scale_b", 40, -5, 1, -100, 0);
    send_one("clamp_a", 32'sh7fffffff, 16'sh7fff, 6'd63, 0, 0);
    send_one("clamp_b", 32'sh7fffffff, -16'sd32768, 6'd63, 0, 0);
    drain();

    // Backpressure: 10 beats, outReady low for cycles 4..9
    idx = 1; exp_idx = 1; first_drop = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clock); #1;
      outReady = !(cyc >= 4 && cyc <= 9);
      inValid  = (idx <= 10);
      accIn    = idx; scaleIn = 1; shiftIn = 0;
      @(negedge clock);
      if (!outReady) begin
        check_val("bp_stall_inready", inReady, 0);
        check_val("bp_stall_valid", outValid, 1);
        check_val("bp_stall_data", outData, exp_idx);
      end
      if (first_drop < 0 && inValid && !inReady) begin
        first_drop = cyc;
        held = (idx - 1) - (exp_idx - 1);
        check_val("bp_held_beats", held, 3);
      end
      if (outValid && outReady) begin
        check_val("bp_order", outData, exp_idx);
        $display("bp out: cycle %0d data=%0d", cyc, outData);
        exp_idx++;
      end
      if (inValid && inReady) idx++;
    end
    inValid = 1'b0;
    check_val("bp_delivered", exp_idx - 1, 10);
    check_val("bp_drop_cycle", first_drop, 4);

    // Reset while beats are in flight
    clear_pulse();
    stream(5, 100000, 1, 0);
    drain();
    @(negedge clock);
    check_val("pre_rst_satcount", satCount, 5);
    check_val("pre_rst_beatcount", beatCount, 5);
    @(posedge clock); #1;
    outReady = 1'b0;
    stream(3, 55, 1, 0);
    check_val("pre_rst_valid", outValid, 1);
    check_val("pre_rst_inready", inReady, 0);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_rst_valid", outValid, 0);
    check_val("async_rst_data", outData, 0);
    check_val("async_rst_satcount", satCount, 0);
    check_val("async_rst_beatcount", beatCount, 0);
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val("post_rst_no_stale", outValid, 0);
    end
    send_one("post_rst", 7, 1, 0, 7, 0);
    drain();

    // Counter saturation and wrap
    clear_pulse();
    stream(65535, 100000, 1, 0);
    drain();
    @(negedge clock);
    check_val("cnt_sat_full", satCount, 65535);
    check_val("cnt_beat_full", beatCount, 65535);
    stream(1, 100000, 1, 0);
    drain();
    @(negedge clock);
    check_val("cnt_sat_sticks", satCount, 65535);
    check_val("cnt_beat_wraps", beatCount, 0);

    // Clear coincident with a delivery
    stream(1, 100000, 1, 0);
    @(posedge clock);
    @(posedge clock); #1;
    clearCounts = 1'b1;
    @(negedge clock);
    check_val("clr_coinc_valid", outValid, 1);
    @(posedge clock); #1;
    clearCounts = 1'b0;
    @(negedge clock);
    check_val("clr_coinc_sat", satCount, 0);
    check_val("clr_coinc_beat", beatCount, 0);
    check_val("clr_coinc_drained", outValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/integer_pe_requant.md
Name: integer_pe_requant

Overview:
- Downstream drain stage for the integer systolic PE.
- Consumes the signed ACC-bit accumulator value (cOut) once a PE's dot product completes.
- Applies a per-beat signed scale multiply, a round-half-up arithmetic right shift and saturation to a signed OUT-bit result.
- 3-stage valid/ready pipeline with bubble collapsing; keeps a saturation-event counter for calibration.

Parameters:
- ACC, 32, accumulator input width (signed)
- OUT, 8, output width (signed)
- SCALE, 16, scale multiplier width (signed)
- SHIFT_BITS, 6, width of the shift amount
- CNT, 16, width of the saturation and output-beat counters

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- accIn  in  ACC  signed accumulator value from PE cOut
- scaleIn  in  SCALE  signed multiplier, sampled with accIn
- shiftIn  in  SHIFT_BITS  right-shift amount, sampled with accIn
- inValid  in  1  accIn/scaleIn/shiftIn valid
- inReady  out  1  block accepts a beat this cycle
- outData  out  OUT  signed requantized result
- outSat  out  1  this outData beat was saturated
- outValid  out  1  outData/outSat valid
- outReady  in  1  consumer accepts a beat
- clearCounts  in  1  synchronous clear of both counters
- satCount  out  CNT  saturated beats delivered, sticks at all-ones
- beatCount  out  CNT  beats delivered, wraps modulo 2^CNT

Behaviour:
- Reset (async assert, any time): all stage valids = 0; outValid = 0, outData = 0, outSat = 0, satCount = 0, beatCount = 0. In-flight beats are discarded.
- Stage advance rule:
  - Stage k loads when it is empty or stage k+1 loads this cycle (stage 3 drains when outReady).
  - inReady = !v1 | stage-1 advance; it is combinational from outReady through the chain.
  - A beat is accepted when inValid & inReady.
- Stage 1: registers accIn, scaleIn, and shift clamped to min(shiftIn, ACC+SCALE-1) = 47.
- Stage 2: prod = signed(acc) * signed(scale), full ACC+SCALE = 48 bits, no truncation.
- Stage 3: rounding and saturation.
  - If shift = 0: r = prod.
  - Otherwise: r = (prod + (1 << (shift-1))) >>> shift, computed at ACC+SCALE+1 bits so the add cannot overflow. Ties round toward +infinity.
  - Saturate: r > 2^(OUT-1)-1 gives 127 with sat = 1; r < -2^(OUT-1) gives -128 with sat = 1; otherwise the low OUT bits with sat = 0.
- Latency: 3 cycles from accept to outValid with no backpressure. Throughput 1 beat/cycle with continuous outReady.
- Backpressure:
  - Holding outReady = 0 freezes stage 3; outData and outSat must stay stable while outValid & !outReady.
  - Upstream stages fill, and inReady falls only when all 3 stages are full.
  - Beats are never dropped, duplicated or reordered.
- Counters:
  - Update on each delivered beat (outValid & outReady): beatCount += 1 (wraps); satCount += outSat, saturating at 2^CNT-1.
  - clearCounts zeroes both counters next edge. If clearCounts coincides with a delivery, the clear wins and counters read 0.
- inValid deasserted mid-stream inserts bubbles. Bubbles collapse when downstream is stalled.
- Inputs may change arbitrarily when inValid = 0 with no effect.

Test Plan:
- Exact and rounding cases (scale = 1, shift = 3, outReady = 1):
  - accIn = 1000 -> outData = 125, outSat = 0, outValid exactly 3 cycles after accept.
  - accIn = 1004 -> 126 (tie rounds up).
  - accIn = -1004 -> -125.
- Saturation (scale = 1, shift = 0):
  - accIn = 100000 -> 127, outSat = 1.
  - accIn = -100000 -> -128, outSat = 1.
  - satCount = 2 and beatCount = 2 after both deliver.
- Scale/shift path: accIn = -300, scale = 3, shift = 2 -> prod = -900, r = -225 -> -128, sat = 1. Then accIn = 40, scale = -5, shift = 1 -> -100, sat = 0. Then shiftIn = 63 with acc = 2^31-1, scale = 2^15-1 -> clamped shift 47 -> 0.
- Backpressure:
  - Stream of 10 beats with values 1..10 (scale = 1, shift = 0); outReady low for cycles 4-9.
  - inReady drops after 3 beats are held.
  - Outputs are 1..10 in order, each exactly once.
  - outData stays stable during the stall.
- Reset mid-operation: 3 beats in flight plus satCount = 5, then assert reset asynchronously between edges -> outValid = 0 and counters = 0 immediately, no stale beat after release. Next beat accIn = 7, scale = 1, shift = 0 -> 7 after 3 cycles.
- Counter edges:
  - 65535 saturated beats, then 1 more -> satCount holds 65535; beatCount wraps to 0 at 65536.
  - clearCounts coincident with a delivery -> both counters read 0.
